// File: rtl/hstm_init_if.sv
// Hand-shake task manager initiator bus.
// Carries both the local command side (start/data_in/ready/done/err) and the
// responder side (req/busy/hstm_data) of an hstm_init instance.
// master: the hstm_init view.  slave: the environment driving it.
interface hstm_init_if #(
    parameter int P_DATA_WIDTH = 1
) ();
    logic                    start;
    logic [P_DATA_WIDTH-1:0] data_in;
    logic                    ready;
    logic                    done;
    logic                    err;
    logic                    req;
    logic                    busy;
    logic [P_DATA_WIDTH-1:0] hstm_data;

    modport master (
        input  start, data_in, busy,
        output ready, done, err, req, hstm_data
    );

    modport slave (
        output start, data_in, busy,
        input  ready, done, err, req, hstm_data
    );
endinterface

// File: rtl/hstm_init.sv
// Initiator side of the hand-shake task manager.
// Accepts a local start command, raises req toward an hstm responder, follows
// the responder's busy through a 2-flop synchronizer, drops req once busy
// completes and keeps hstm_data stable for P_HOLD_CNT cycles afterwards.
// Optional feature macro: HSTM_INIT_TIMEOUT_EN enables per-phase timeouts on
// S_REQ and S_BUSY that set the sticky err flag.
module hstm_init #(
    parameter int P_DATA_WIDTH = 1,
    parameter int P_HOLD_CNT   = 6,
    parameter int P_TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    hstm_init_if.master   bus
);

    localparam int P_CNT_MAX = (P_TIMEOUT > P_HOLD_CNT) ? P_TIMEOUT : P_HOLD_CNT;
    localparam int CNT_W     = $clog2(P_CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(P_HOLD_CNT - 1);
`ifdef HSTM_INIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(P_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    busy_meta_q, busy_s_q;

    // Two-flop synchronizer: busy comes from the responder's clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= bus.busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // State, phase counter, request and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

`ifdef HSTM_INIT_TIMEOUT_EN
    logic err_q, err_d;

    // Sticky timeout flag, cleared only by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Next-state logic: handshake sequencing and phase counting.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
`ifdef HSTM_INIT_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.data_in;
                    req_d   = 1'b1;
`ifdef HSTM_INIT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (busy_s_q) begin
                    state_d = S_BUSY;
                end
`ifdef HSTM_INIT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_HOLD;
                end
`endif
            end
            S_BUSY: begin
                if (!busy_s_q) begin
                    req_d   = 1'b0;
                    state_d = S_HOLD;
                end
`ifdef HSTM_INIT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Counter restarts on every state entry; it saturates so an endless
        // wait (timeout disabled) can never alias back to a small value.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ || state_q == S_BUSY || state_q == S_HOLD)
                     && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.req       = req_q;
    assign bus.hstm_data = data_q;
`ifdef HSTM_INIT_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_hstm_init.sv
// Bench for hstm_init: behavioural hstm responder in loopback on the same
// clock, a scoreboard of expected completions popped by a done monitor, and
// directed checks of reset, timing, ignored starts and back-to-back tasks.
module tb_hstm_init;

    localparam int W        = 8;
    localparam int HOLD     = 6;
    localparam int TMO      = 16;
    localparam int BUSY_LEN = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hstm_init_if #(.P_DATA_WIDTH(W)) bus_if ();

    hstm_init #(
        .P_DATA_WIDTH(W),
        .P_HOLD_CNT  (HOLD),
        .P_TIMEOUT   (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        bit           chk_resp;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- responder model ----------------
    logic         busy_r   = 1'b0;
    logic [W-1:0] resp_out = '0;
    int           r_state  = 0;
    int           r_cnt    = 0;
    bit           resp_en  = 1'b1;
    assign bus_if.busy = busy_r;

    always @(posedge clk) begin
        case (r_state)
            0: if (resp_en && bus_if.req) begin
                resp_out <= bus_if.hstm_data;
                busy_r   <= 1'b1;
                r_cnt    <= 0;
                r_state  <= 1;
            end
            1: if (!bus_if.req) begin
                busy_r  <= 1'b0;
                r_state <= 0;
            end else if (r_cnt == BUSY_LEN - 1) begin
                busy_r  <= 1'b0;
                r_state <= 2;
            end else begin
                r_cnt <= r_cnt + 1;
            end
            default: if (!bus_if.req) r_state <= 0;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return bus_if.ready;
            1:       return bus_if.busy;
            2:       return bus_if.req;
            default: return bus_if.done;
        endcase
    endfunction

    // Wait (on negedges) until signal s equals v; n returns cycles waited.
    task automatic wait_for(input int s, input logic v, input int limit,
                            input string name, output int n);
        n = 0;
        while (sig(s) !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(s) !== v) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, limit);
        end
    endtask

    // ---------------- done monitor / scoreboard ----------------
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && bus_if.done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none (hstm_data=%0h)",
                         bus_if.hstm_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_hstm_data", {24'd0, bus_if.hstm_data}, {24'd0, e.data});
                check("sb_err", {31'd0, bus_if.err}, {31'd0, e.err});
                if (e.chk_resp)
                    check("sb_resp_out", {24'd0, resp_out}, {24'd0, e.data});
            end
        end
        prev_done = rst_n && bus_if.done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   {31'd0, bus_if.req},   32'd0);
        check("rst_data",  {24'd0, bus_if.hstm_data}, 32'd0);
        check("rst_done",  {31'd0, bus_if.done},  32'd0);
        check("rst_err",   {31'd0, bus_if.err},   32'd0);
        check("rst_ready", {31'd0, bus_if.ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single task 0xA5, with an ignored start during S_BUSY.
        exp_q.push_back('{8'hA5, 1'b0, 1'b1});
        bus_if.data_in = 8'hA5;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("acc_ready", {31'd0, bus_if.ready}, 32'd0);
        check("acc_req",   {31'd0, bus_if.req},   32'd1);
        check("acc_data",  {24'd0, bus_if.hstm_data}, 32'hA5);
        wait_for(1, 1'b1, 50, "wait_busy_hi", n);
        repeat (4) @(negedge clk);
        bus_if.data_in = 8'h3C;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("ign_data",  {24'd0, bus_if.hstm_data}, 32'hA5);
        wait_for(1, 1'b0, 50, "wait_busy_lo", n);
        wait_for(2, 1'b0, 20, "wait_req_lo", n);
        check("req_fall_lat", n, 3);
        check("hold_data", {24'd0, bus_if.hstm_data}, 32'hA5);
        wait_for(3, 1'b1, 30, "wait_done", n);
        check("hold_len", n, HOLD);
        @(negedge clk);
        check("post_done_ready", {31'd0, bus_if.ready}, 32'd1);
        check("post_done_data",  {24'd0, bus_if.hstm_data}, 32'hA5);
        repeat (20) @(negedge clk);

        // Back-to-back with start held high.
        exp_q.push_back('{8'h01, 1'b0, 1'b1});
        exp_q.push_back('{8'h02, 1'b0, 1'b1});
        bus_if.data_in = 8'h01;
        bus_if.start   = 1'b1;
        @(negedge clk);
        check("b2b_data1", {24'd0, bus_if.hstm_data}, 32'h01);
        bus_if.data_in = 8'h02;
        wait_for(0, 1'b1, 100, "wait_ready_b2b", n);
        n = 0;
        while (bus_if.ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b2b_idle_gap", n, 1);
        check("b2b_data2", {24'd0, bus_if.hstm_data}, 32'h02);
        bus_if.start = 1'b0;
        wait_for(3, 1'b1, 100, "wait_done_b2b", n);
        @(negedge clk);
        check("b2b_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of S_BUSY: no completion expected.
        bus_if.data_in = 8'h77;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_for(1, 1'b1, 50, "wait_busy_rst", n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   {31'd0, bus_if.req},   32'd0);
        check("arst_data",  {24'd0, bus_if.hstm_data}, 32'd0);
        check("arst_ready", {31'd0, bus_if.ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'd0, bus_if.ready}, 32'd1);
        check("rel_req",   {31'd0, bus_if.req},   32'd0);
        repeat (20) @(negedge clk);

`ifdef HSTM_INIT_TIMEOUT_EN
        // Responder silent: request phase times out.
        resp_en = 1'b0;
        exp_q.push_back('{8'h5A, 1'b1, 1'b0});
        bus_if.data_in = 8'h5A;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_for(2, 1'b0, 40, "wait_tmo_req_lo", n);
        check("tmo_req_len", n, TMO);
        check("tmo_err", {31'd0, bus_if.err}, 32'd1);
        wait_for(3, 1'b1, 30, "wait_tmo_done", n);
        check("tmo_hold_len", n, HOLD);
        @(negedge clk);
        check("tmo_err_sticky", {31'd0, bus_if.err}, 32'd1);
        resp_en = 1'b1;
        exp_q.push_back('{8'h11, 1'b0, 1'b1});
        bus_if.data_in = 8'h11;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("tmo_err_clear", {31'd0, bus_if.err}, 32'd0);
        wait_for(3, 1'b1, 100, "wait_done_after_tmo", n);
        @(negedge clk);
`else
        // Responder silent: without timeouts the request waits indefinitely.
        begin
            bit req_dropped = 1'b0;
            bit err_seen    = 1'b0;
            resp_en = 1'b0;
            bus_if.data_in = 8'h5A;
            bus_if.start   = 1'b1;
            @(negedge clk);
            bus_if.start = 1'b0;
            repeat (1000) begin
                @(negedge clk);
                if (bus_if.req !== 1'b1) req_dropped = 1'b1;
                if (bus_if.err !== 1'b0) err_seen    = 1'b1;
            end
            check("notmo_req_held", {31'd0, req_dropped}, 32'd0);
            check("notmo_err",      {31'd0, err_seen},    32'd0);
            check("notmo_ready",    {31'd0, bus_if.ready}, 32'd0);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n   = 1'b1;
            resp_en = 1'b1;
            @(negedge clk);
        end
`endif

        check("final_sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
